// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter that shares the async FIFO write
//               port among NUM_REQ valid/ready requesters (write domain).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam int                 c_IDX_W     = $clog2(NUM_REQ);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_IDX_W:0]   c_NREQ      = (c_IDX_W + 1)'(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST_REQ  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   w_owner_nxt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic [c_CNT_W-1:0]   w_beat_nxt;

    logic [c_IDX_W:0]     w_sum;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_found;
    logic                 w_owner_valid;
    logic                 w_xfer;
    logic                 w_last_beat;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search: first valid requester strictly after last_grant, with wrap.
    always_comb begin
        w_sum   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_grant} + (c_IDX_W + 1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (!w_found && req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_owner_valid = req_valid[r_owner];
    assign w_xfer        = (r_state == S_BURST) && w_owner_valid && !wfull;
    assign w_last_beat   = (r_beat_cnt == c_LAST_BEAT);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_grant <= c_LAST_REQ;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_grant;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BURST;
                    w_grant_nxt = c_ONE_HOT0 << w_pick;
                    w_owner_nxt = w_pick;
                    w_beat_nxt  = '0;
                end
            end
            S_BURST: begin
                // Withdrawal releases even while stalled on wfull.
                if (!w_owner_valid || (w_xfer && w_last_beat)) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_owner;
                    w_beat_nxt  = '0;
                end else if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        winc      = w_xfer;
        req_ready = w_xfer ? r_grant : '0;
        wdata     = (r_grant == '0) ? '0 : w_slice[r_owner];
        grant     = r_grant;
        busy      = (r_state == S_BURST);
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Scoreboard bench for fifo_write_arbiter (per-requester order).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          wclk = 1'b0;
    logic                          wrst = 1'b1;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull = 1'b0;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    logic [DATA_WIDTH-1:0] src_q [NUM_REQ][$];
    logic [DATA_WIDTH-1:0] exp_q [NUM_REQ][$];
    logic [NUM_REQ-1:0]    en = '0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int grant_log[$];
    int burst_log[$];
    int gap_log[$];
    int beats   = 0;
    int gap_cnt = 0;
    bit mon_on  = 1'b0;

    logic [NUM_REQ-1:0]    prev_grant = '0;
    logic [NUM_REQ-1:0]    prev_valid = '0;
    logic [NUM_REQ-1:0]    prev_ready = '0;
    logic [DATA_WIDTH-1:0] prev_data [NUM_REQ];

    logic [NUM_REQ-1:0]    s_grant, s_ready, s_valid;
    logic                  s_winc, s_busy;
    logic [DATA_WIDTH-1:0] s_wdata;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int gidx(input logic [NUM_REQ-1:0] g);
        int r = 0;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic push_word(input int r, input logic [DATA_WIDTH-1:0] w);
        src_q[r].push_back(w);
        exp_q[r].push_back(w);
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = en[i] && (src_q[i].size() > 0);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic monitor();
        logic exp_winc;
        s_grant = grant; s_ready = req_ready; s_valid = req_valid;
        s_winc  = winc;  s_busy  = busy;      s_wdata = wdata;
        if (!mon_on) return;
        exp_winc = (grant != '0) && ((req_valid & grant) != '0) && !wfull;
        check_value("no_winc_when_full", 32'(winc & wfull), 32'd0);
        check_value("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check_value("winc_rule", 32'(winc), 32'(exp_winc));
        check_value("ready_rule", 32'(req_ready), exp_winc ? 32'(grant) : 32'd0);
        check_value("busy_vs_grant", 32'(busy), 32'(grant != '0));
        if (grant == '0) check_value("wdata_idle", 32'(wdata), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prev_valid[i] && !prev_ready[i] && req_valid[i])
                check_value("data_stable", 32'(req_data[i*DATA_WIDTH +: DATA_WIDTH]), 32'(prev_data[i]));
        end
        if (grant != prev_grant) begin
            if (prev_grant != '0) begin
                burst_log.push_back(beats);
                check_value("burst_len_max", 32'(beats <= MAX_BURST), 32'd1);
                gap_cnt = 0;
            end
            if (grant != '0) begin
                grant_log.push_back(int'(grant));
                gap_log.push_back(gap_cnt);
                gap_cnt = 0;
                beats   = 0;
            end
        end
        if (grant == '0) gap_cnt++;
        if (winc) begin
            int o;
            o = gidx(grant);
            beats++;
            if (exp_q[o].size() == 0) check_value("sb_underflow", 32'd0, 32'd1);
            else                      check_value("wdata_order", 32'(wdata), 32'(exp_q[o].pop_front()));
        end
        prev_grant = grant;
        prev_valid = req_valid;
        prev_ready = req_ready;
        for (int i = 0; i < NUM_REQ; i++) prev_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    endtask

    task automatic tick();
        drive();
        @(negedge wclk);
        monitor();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_ready[i] === 1'b1 && s_valid[i] === 1'b1 && src_q[i].size() > 0)
                void'(src_q[i].pop_front());
        end
    endtask

    task automatic do_reset();
        wrst = 1'b1; en = '0; wfull = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        tick();
        tick();
        check_value("rst_grant", 32'(s_grant), 32'd0);
        check_value("rst_winc",  32'(s_winc),  32'd0);
        check_value("rst_busy",  32'(s_busy),  32'd0);
        check_value("rst_ready", 32'(s_ready), 32'd0);
        check_value("rst_wdata", 32'(s_wdata), 32'd0);
        wrst = 1'b0;
        mon_on = 1'b1;
        prev_grant = '0; prev_valid = '0; prev_ready = '0;
        grant_log.delete(); burst_log.delete(); gap_log.delete();
        gap_cnt = 0; beats = 0;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [DATA_WIDTH-1:0] w;

        // Single requester stream: 4-word burst, 1 idle, re-grant for the tail.
        do_reset();
        for (int k = 0; k < 6; k++) push_word(0, 8'hA0 + 8'(k));
        en = 4'b0001;
        tick();
        check_value("t1_arb_latency", 32'(s_grant), 32'd0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                check_value("t1_grant", 32'(s_grant), 32'h1);
                check_value("t1_first_word", 32'(s_wdata), 32'hA0);
            end
            cnt += int'(s_winc);
        end
        check_value("t1_burst_beats", 32'(cnt), 32'd4);
        tick();
        check_value("t1_idle_gap", 32'(s_busy), 32'd0);
        tick();
        check_value("t1_regrant", 32'(s_grant), 32'h1);
        check_value("t1_word4", 32'(s_wdata), 32'hA4);
        tick();
        check_value("t1_word5", 32'(s_wdata), 32'hA5);
        tick(); tick();
        check_value("t1_drained", 32'(exp_q[0].size()), 32'd0);

        // All requesters valid: rotation 0,1,2,3,0 with full bursts.
        do_reset();
        for (int r = 0; r < NUM_REQ; r++)
            for (int k = 0; k < 20; k++) push_word(r, 8'((r << 5) | k));
        en = 4'b1111;
        guard = 0;
        while (grant_log.size() < 5 && guard < 200) begin
            tick();
            guard++;
        end
        check_value("t2_grants_seen", 32'(grant_log.size() >= 5), 32'd1);
        if (grant_log.size() >= 5) begin
            check_value("t2_order0", 32'(grant_log[0]), 32'h1);
            check_value("t2_order1", 32'(grant_log[1]), 32'h2);
            check_value("t2_order2", 32'(grant_log[2]), 32'h4);
            check_value("t2_order3", 32'(grant_log[3]), 32'h8);
            check_value("t2_order4", 32'(grant_log[4]), 32'h1);
            for (int b = 0; b < 4; b++) check_value("t2_burst_len", 32'(burst_log[b]), 32'd4);
            for (int b = 1; b < 5; b++) check_value("t2_gap", 32'(gap_log[b]), 32'd1);
        end

        // Owner 1 stalls on wfull for 5 cycles after 2 words.
        do_reset();
        for (int k = 0; k < 10; k++) push_word(1, 8'h10 + 8'(k));
        en = 4'b0010;
        tick(); tick(); tick();
        check_value("t3_pre_stall", 32'(s_winc), 32'd1);
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_value("t3_stall_winc",  32'(s_winc),  32'd0);
            check_value("t3_stall_ready", 32'(s_ready), 32'd0);
            check_value("t3_stall_grant", 32'(s_grant), 32'h2);
        end
        wfull = 1'b0;
        cnt = 0;
        tick(); cnt += int'(s_winc);
        tick(); cnt += int'(s_winc);
        check_value("t3_resume_words", 32'(cnt), 32'd2);
        tick();
        check_value("t3_release", 32'(s_grant), 32'd0);

        // Owner 2 withdraws after one word while requester 3 waits.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_word(2, 8'h20 + 8'(k));
            push_word(3, 8'h30 + 8'(k));
        end
        en = 4'b1100;
        tick(); tick();
        check_value("t4_owner2", 32'(s_grant), 32'h4);
        en[2] = 1'b0;
        tick();
        check_value("t4_drop_no_winc", 32'(s_winc), 32'd0);
        tick();
        check_value("t4_idle", 32'(s_grant), 32'd0);
        en[2] = 1'b1;
        tick();
        check_value("t4_grant3", 32'(s_grant), 32'h8);
        guard = 0;
        while (grant_log.size() < 3 && guard < 50) begin
            tick();
            guard++;
        end
        check_value("t4_grants_seen", 32'(grant_log.size() >= 3), 32'd1);
        if (grant_log.size() >= 3) begin
            check_value("t4_short_burst", 32'(burst_log[0]), 32'd1);
            check_value("t4_burst3", 32'(burst_log[1]), 32'd4);
            check_value("t4_back_to_2", 32'(grant_log[2]), 32'h4);
        end

        // Reset in the middle of owner 3's burst.
        do_reset();
        for (int k = 0; k < 10; k++) push_word(3, 8'h30 + 8'(k));
        en = 4'b1000;
        tick(); tick(); tick();
        check_value("t5_owner3", 32'(s_grant), 32'h8);
        wrst = 1'b1;
        en = 4'b1111;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 6; k++) push_word(r, 8'((r << 4) | k));
        tick();
        wrst = 1'b0;
        tick();
        check_value("t5_rst_grant", 32'(s_grant), 32'd0);
        check_value("t5_rst_winc",  32'(s_winc),  32'd0);
        check_value("t5_rst_busy",  32'(s_busy),  32'd0);
        tick();
        check_value("t5_first_grant", 32'(s_grant), 32'h1);

        // Random valid / wfull traffic followed by a drain.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (src_q[r].size() < 3 && $urandom_range(0, 3) == 0) begin
                    w = 8'($urandom);
                    push_word(r, w);
                end
            end
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
            wfull = ($urandom_range(0, 3) == 0);
            tick();
        end
        wfull = 1'b0;
        en = 4'b1111;
        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) > 0
               && guard < 500) begin
            tick();
            guard++;
        end
        for (int r = 0; r < NUM_REQ; r++) check_value("t6_drained", 32'(exp_q[r].size()), 32'd0);
        check_value("t6_activity", 32'(grant_log.size() > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
